// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the target and the master ends of the link.
package i2c_pkg;
  localparam logic [6:0] SLAVE_ADDR_DEF = 7'b1100101;
  localparam logic       ACK            = 1'b0;
  localparam logic       NACK           = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK
  } state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes scl/sda into the system clock domain and flags edges and START/STOP.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [SYNC_STAGES-1:0] scl_q, sda_q;
  logic                   scl_s, scl_p, sda_p;

  assign scl_s = scl_q[SYNC_STAGES-1];
  assign sda_s = sda_q[SYNC_STAGES-1];

  // Sync chains plus one previous-value flop per line; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
      sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  assign scl_rise  =  scl_s & ~scl_p;
  assign scl_fall  = ~scl_s &  scl_p;
  assign start_det =  scl_s &  sda_p & ~sda_s;
  assign stop_det  =  scl_s & ~sda_p &  sda_s;
endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, write-byte receive and read-byte transmit with acks.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = SLAVE_ADDR_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_slave,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       busy
);
  logic       scl_rise, scl_fall, start_det, stop_det, sda_s;
  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n, txsh, txsh_n, rxd_n, byte_in;
  logic       rw, rw_n, ph, ph_n, sda_n, rxv_n, txl_n, busy_n, load;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(sys_clk), .rst(sys_rst), .scl(scl), .sda(sda),
    .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .sda_s(sda_s)
  );

  assign byte_in = {shreg[6:0], sda_s};

  // State and all output registers; sda_slave is registered so reset releases it at once.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      txsh      <= '0;
      rw        <= 1'b0;
      ph        <= 1'b0;
      sda_slave <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shreg     <= shreg_n;
      txsh      <= txsh_n;
      rw        <= rw_n;
      ph        <= ph_n;
      sda_slave <= sda_n;
      rx_data   <= rxd_n;
      rx_valid  <= rxv_n;
      tx_load   <= txl_n;
      busy      <= busy_n;
    end
  end

  // Next-state logic; START/STOP win over any scl edge in the same cycle.
  // ph marks the second half of an ack slot (target: driving ack; TX_ACK: master acked).
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    txsh_n  = txsh;
    rw_n    = rw;
    ph_n    = ph;
    sda_n   = sda_slave;
    rxd_n   = rx_data;
    rxv_n   = 1'b0;
    txl_n   = 1'b0;
    busy_n  = busy;
    load    = 1'b0;
    if (start_det) begin
      state_n = ADDR;
      cnt_n   = '0;
      sda_n   = NACK;
    end else if (stop_det) begin
      state_n = IDLE;
      sda_n   = NACK;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: sda_n = NACK;
        ADDR: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              rw_n    = byte_in[0];
              busy_n  = 1'b1;
              ph_n    = 1'b0;
              state_n = ADDR_ACK;
            end else begin
              busy_n  = 1'b0;
              state_n = IDLE;
            end
          end
        end
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          if (!ph) begin
            sda_n = ACK;
            ph_n  = 1'b1;
          end else if (state == RX_ACK || !rw) begin
            sda_n   = NACK;
            cnt_n   = '0;
            state_n = RX;
          end else begin
            load = 1'b1;
          end
        end
        RX: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rxd_n   = byte_in;
            rxv_n   = 1'b1;
            ph_n    = 1'b0;
            state_n = RX_ACK;
          end
        end
        TX: if (scl_fall) begin
          if (cnt == 3'd7) begin
            sda_n   = NACK;
            cnt_n   = '0;
            ph_n    = 1'b0;
            state_n = TX_ACK;
          end else begin
            sda_n  = txsh[6];
            txsh_n = {txsh[6:0], 1'b0};
            cnt_n  = cnt + 3'd1;
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s == ACK) ph_n = 1'b1;
            else begin
              busy_n  = 1'b0;
              state_n = IDLE;
            end
          end else if (scl_fall && ph) begin
            load = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // Start of a read byte: capture tx_data and drive its MSB right away.
    if (load) begin
      txsh_n  = tx_data;
      txl_n   = 1'b1;
      sda_n   = tx_data[7];
      cnt_n   = '0;
      state_n = TX;
    end
  end
endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged master on a wired-AND sda line.
module tb_i2c_target;
  localparam int Q = 8;  // sys_clk cycles per quarter scl period

  logic       sys_clk = 1'b0;
  logic       sys_rst, scl, sda_m, sda_bus, sda_slave, rx_valid, tx_load, busy;
  logic [7:0] rx_data, tx_data;
  int         n_cmp = 0, n_bad = 0;
  int         rxv_cnt = 0, txl_cnt = 0, low_cnt = 0, both_cnt = 0;
  int         rxv0, txl0, low0;
  logic       ack, r;
  logic [7:0] d;

  assign sda_bus = sda_m & sda_slave;

  i2c_target dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .scl(scl), .sda(sda_bus),
    .sda_slave(sda_slave), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_load(tx_load), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Running counts of pulse cycles and target pull-downs.
  always @(negedge sys_clk) begin
    if (rx_valid === 1'b1) rxv_cnt++;
    if (tx_load === 1'b1) txl_cnt++;
    if (sda_slave === 1'b0) low_cnt++;
    if (rx_valid === 1'b1 && tx_load === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge sys_clk);
  endtask

  task automatic bit_clk(input logic b, output logic rb);
    sda_m = b; wq();
    scl = 1'b1; wq();
    rb = sda_bus; wq();
    scl = 1'b0; wq();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic a);
    logic x;
    for (int i = 7; i >= 0; i--) bit_clk(b[i], x);
    bit_clk(1'b1, a);
  endtask

  task automatic rd_byte(output logic [7:0] b);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      bit_clk(1'b1, x);
      b[i] = x;
    end
  endtask

  initial begin
    sys_rst = 1'b1; scl = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    check("rst_sda", sda_slave, 1'b1);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_load", tx_load, 1'b0);
    check("rst_busy", busy, 1'b0);
    sys_rst = 1'b0; wq();

    // 1: write 0x5A to address 0xCA
    rxv0 = rxv_cnt;
    i2c_start();
    wr_byte(8'hCA, ack); check("t1_addr_ack", ack, 1'b0);
    check("t1_busy", busy, 1'b1);
    wr_byte(8'h5A, ack); check("t1_data_ack", ack, 1'b0);
    check("t1_rx_data", rx_data, 8'h5A);
    check("t1_rxv_cycles", rxv_cnt - rxv0, 1);
    i2c_stop(); wq();
    check("t1_busy_stop", busy, 1'b0);

    // 2: read 0x3C (master ACK) then 0xF0 (master NACK)
    txl0 = txl_cnt; tx_data = 8'h3C;
    i2c_start();
    wr_byte(8'hCB, ack); check("t2_addr_ack", ack, 1'b0);
    rd_byte(d); check("t2_byte0", d, 8'h3C);
    tx_data = 8'hF0;
    bit_clk(1'b0, r);
    rd_byte(d); check("t2_byte1", d, 8'hF0);
    bit_clk(1'b1, r);
    check("t2_busy_nack", busy, 1'b0);
    check("t2_txl_cycles", txl_cnt - txl0, 2);
    check("t2_sda_idle", sda_slave, 1'b1);
    i2c_stop(); wq();

    // 3: wrong address, target must stay off the bus
    rxv0 = rxv_cnt; low0 = low_cnt;
    i2c_start();
    wr_byte(8'hA0, ack); check("t3_addr_nack", ack, 1'b1);
    wr_byte(8'hFF, ack); check("t3_data_nack", ack, 1'b1);
    i2c_stop(); wq();
    check("t3_no_pull", low_cnt - low0, 0);
    check("t3_no_rxv", rxv_cnt - rxv0, 0);
    check("t3_busy", busy, 1'b0);

    // 4: write 0x11, repeated START, read one byte, NACK
    i2c_start();
    wr_byte(8'hCA, ack); check("t4_addr_ack", ack, 1'b0);
    wr_byte(8'h11, ack); check("t4_data_ack", ack, 1'b0);
    check("t4_rx_data", rx_data, 8'h11);
    txl0 = txl_cnt; tx_data = 8'h96;
    i2c_start();
    wr_byte(8'hCB, ack); check("t4_sr_ack", ack, 1'b0);
    check("t4_txl_at_read", txl_cnt - txl0, 1);
    rd_byte(d); check("t4_byte", d, 8'h96);
    bit_clk(1'b1, r);
    check("t4_busy_nack", busy, 1'b0);
    check("t4_rx_kept", rx_data, 8'h11);
    i2c_stop(); wq();

    // 5: reset asserted while the target holds the ack low
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_clk(d[0] ^ d[0] ^ (8'hCA >> i), r);
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    check("t5_ack_low", sda_slave, 1'b0);
    sys_rst = 1'b1; #1;
    check("t5_rst_release", sda_slave, 1'b1);
    check("t5_rst_busy", busy, 1'b0);
    @(negedge sys_clk); sys_rst = 1'b0; wq();
    scl = 1'b0; wq();
    i2c_stop(); wq();
    i2c_start();
    wr_byte(8'hCA, ack); check("t5_addr_ack", ack, 1'b0);
    wr_byte(8'h77, ack); check("t5_data_ack", ack, 1'b0);
    i2c_stop(); wq();
    check("t5_rx_data", rx_data, 8'h77);

    // 6: STOP after four data bits of a write
    i2c_start();
    wr_byte(8'hCA, ack); check("t6_addr_ack", ack, 1'b0);
    rxv0 = rxv_cnt;
    for (int i = 0; i < 4; i++) bit_clk(i[0], r);
    i2c_stop(); wq();
    check("t6_no_rxv", rxv_cnt - rxv0, 0);
    check("t6_rx_kept", rx_data, 8'h77);
    check("t6_busy", busy, 1'b0);
    check("t6_sda", sda_slave, 1'b1);
    check("no_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
